// File: rtl/input_debouncer_pkg.sv
// Shared defaults, per-channel output bundle and width helpers for the input debouncer.
// Board channel map: bits [3:0] are BTN, bits [7:4] are SW.
package input_debouncer_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIV    = 250000;
    localparam int DEF_STABLE = 3;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic sticky;
    } ch_out_t;

    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Raw board inputs in, debounced level/edges/sticky out.
// Free-running level signals; no handshake or backpressure.
interface input_debouncer_if
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sticky;
    logic             tick;

    modport master (
        output din, clr,
        input  level, rise, fall, sticky, tick
    );

    modport slave (
        input  din, clr,
        output level, rise, fall, sticky, tick
    );
endinterface

// File: rtl/input_debouncer_ch.sv
// One channel: 2-flop synchroniser, tick-gated stability counter, level, edge pulses, sticky rise.
// Latency: 2 clk sync + STABLE ticks to level; no backpressure.
module input_debouncer_ch
    import input_debouncer_pkg::*;
#(
    parameter int STABLE = DEF_STABLE
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    tick,
    input  logic    din,
    input  logic    clr,
    output ch_out_t q
);

    localparam int CW = cnt_width(STABLE);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          sticky_q, sticky_d;

    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (tick) begin
            if (s2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE - 1)) begin
                level_d = s2_q;
                cnt_d   = '0;
                rise_d  = s2_q;
                fall_d  = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // A rise landing on the same edge as a clear must survive.
        sticky_d = sticky_q;
        if (clr)    sticky_d = 1'b0;
        if (rise_d) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sticky_q <= sticky_d;
        end
    end

    assign q = '{level: level_q, rise: rise_q, fall: fall_q, sticky: sticky_q};

endmodule

// File: rtl/input_debouncer.sv
// Shared sample-tick prescaler feeding WIDTH independent debounce channels.
// Latency: 2 + (STABLE-1)*DIV + 1 .. 2 + STABLE*DIV clk input to level; no backpressure.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIV    = DEF_DIV,
    parameter int STABLE = DEF_STABLE
) (
    input  logic              clk,
    input  logic              reset,
    input_debouncer_if.slave  io
);

    localparam int PW = presc_width(DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] sticky_w;

    // Wraps straight from DIV-1 to 0 so ticks are exactly DIV clk apart.
    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) presc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        ch_out_t ch_o;

        input_debouncer_ch #(
            .STABLE (STABLE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .din   (io.din[i]),
            .clr   (io.clr[i]),
            .q     (ch_o)
        );

        assign level_w[i]  = ch_o.level;
        assign rise_w[i]   = ch_o.rise;
        assign fall_w[i]   = ch_o.fall;
        assign sticky_w[i] = ch_o.sticky;
    end

    assign io.level  = level_w;
    assign io.rise   = rise_w;
    assign io.fall   = fall_w;
    assign io.sticky = sticky_w;
    assign io.tick   = tick;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: each scenario pushes the expected edge event (with the tick index it must
// appear after) into a scoreboard; a negedge monitor pops and compares on every rise/fall.
module tb_input_debouncer;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int ST  = 3;

    typedef struct {
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] level;
        logic [W-1:0] sticky;
        int           tk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    input_debouncer_if #(.WIDTH(W)) io ();

    input_debouncer #(
        .WIDTH  (W),
        .DIV    (DIV),
        .STABLE (ST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_ev(input logic [W-1:0] r, input logic [W-1:0] f,
                             input logic [W-1:0] l, input logic [W-1:0] s, input int tk);
        exp_t e;
        e.rise = r; e.fall = f; e.level = l; e.sticky = s; e.tk = tk;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    // Returns in cycle 0: the first posedge after return is the first one with reset low.
    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Monitor
    int   tick_cnt  = 0;
    int   last_tick = -1;
    int   mcyc      = 0;
    exp_t m_e;

    always @(negedge clk) begin
        mcyc++;
        if (reset) begin
            tick_cnt  = 0;
            last_tick = -1;
        end else begin
            if (io.tick) begin
                if (last_tick >= 0) check("tick_gap", mcyc - last_tick, DIV);
                last_tick = mcyc;
                tick_cnt++;
            end
            if (io.rise != '0 || io.fall != '0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_edge: got rise=%h fall=%h expected no edge",
                             io.rise, io.fall);
                end else begin
                    m_e = sb.pop_front();
                    check("ev_rise",   io.rise,   m_e.rise);
                    check("ev_fall",   io.fall,   m_e.fall);
                    check("ev_level",  io.level,  m_e.level);
                    check("ev_sticky", io.sticky, m_e.sticky);
                    check("ev_tick",   tick_cnt,  m_e.tk);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Reset with inputs held high
        io.din = 8'hFF;
        io.clr = '0;
        reset  = 1'b1;
        step(20);
        check("rst_level",  io.level,  8'h00);
        check("rst_rise",   io.rise,   8'h00);
        check("rst_fall",   io.fall,   8'h00);
        check("rst_sticky", io.sticky, 8'h00);
        check("rst_tick",   io.tick,   1'b0);
        reset = 1'b0;
        cyc   = 0;
        expect_ev(8'hFF, 8'h00, 8'hFF, 8'hFF, 3);
        goto(13);
        check("rst_rise_one_clk", io.rise,   8'h00);
        check("rst_level_hi",     io.level,  8'hFF);
        check("rst_sticky_hi",    io.sticky, 8'hFF);
        io.clr = 8'hFF;
        step(1);
        io.clr = '0;
        check("clr_all", io.sticky, 8'h00);
        goto(20);

        // Glitch of two ticks on bit 0, then a clean press needing three fresh ticks
        io.din = '0;
        do_reset(2);
        io.din = 8'h01;
        goto(8);
        io.din = 8'h00;
        goto(16);
        check("glitch_level",  io.level,  8'h00);
        check("glitch_sticky", io.sticky, 8'h00);
        io.din = 8'h01;
        expect_ev(8'h01, 8'h00, 8'h01, 8'h01, 7);
        goto(26);
        check("glitch_recount", io.level, 8'h00);
        goto(30);
        check("glitch_after", io.level, 8'h01);

        // Clean press then release on bit 1
        io.din = '0;
        do_reset(2);
        io.din = 8'h02;
        expect_ev(8'h02, 8'h00, 8'h02, 8'h02, 3);
        goto(20);
        check("press_level", io.level, 8'h02);
        io.din = 8'h00;
        expect_ev(8'h00, 8'h02, 8'h00, 8'h02, 8);
        goto(34);
        check("release_level", io.level, 8'h00);

        // Sticky set and clear on the same edge: set wins, clear lands next edge
        io.din = '0;
        do_reset(2);
        io.din = 8'h04;
        goto(11);
        io.clr = 8'h04;
        expect_ev(8'h04, 8'h00, 8'h04, 8'h04, 3);
        step(2);
        io.clr = '0;
        check("collide_cleared", io.sticky, 8'h00);
        check("collide_level",   io.level,  8'h04);
        goto(16);

        // Several channels on one tick, both directions
        io.din = '0;
        do_reset(2);
        io.din = 8'hA5;
        expect_ev(8'hA5, 8'h00, 8'hA5, 8'hA5, 3);
        goto(16);
        io.din = 8'h00;
        expect_ev(8'h00, 8'hA5, 8'h00, 8'hA5, 7);
        goto(30);

        // Reset after two ticks of a pending press discards the partial count
        io.din = '0;
        do_reset(2);
        io.din = 8'h08;
        goto(8);
        check("mid_pre_level", io.level, 8'h00);
        do_reset(1);
        check("mid_post_level", io.level, 8'h00);
        expect_ev(8'h08, 8'h00, 8'h08, 8'h08, 3);
        goto(11);
        check("mid_not_early", io.level, 8'h00);
        goto(16);
        check("mid_level", io.level, 8'h08);

        for (int i = 0; i < 100 && sb.size() != 0; i++) step(1);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
